tiny_dnn_stream_host: RTL and testbench

- Host-side stream endpoint for tiny_dnn_top: the transmitter for its src stream and the receiver for its dst stream.
- Holds a preloaded source frame in local memory and streams it out with valid/ready/last.
- Then captures the returned result frame into a local result memory and reports done/error.
- Used as the bench/SoC-side driver for weight, bias and activation transfers.

---
 rtl/tiny_dnn_stream_pkg.sv | 16 +
 rtl/tiny_dnn_stream_host_if.sv | 16 +
 rtl/tiny_dnn_stream_tx.sv | 131 +++++++++++++
 rtl/tiny_dnn_stream_host.sv | 129 ++++++++++++
 tb/tb_tiny_dnn_stream_host.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tiny_dnn_stream_pkg.sv
// Shared defaults and types for the tiny_dnn host stream endpoint.
package tiny_dnn_stream_pkg;

   localparam int unsigned DwDef = 32;
   localparam int unsigned AwDef = 12;

   typedef logic [DwDef-1:0] word_t;

   typedef enum logic [1:0] {
      StIdle,
      StSend,
      StRecv,
      StDone
   } state_e;

endpackage

// File: rtl/tiny_dnn_stream_host_if.sv
// valid/ready/last word stream; master drives the payload, slave drives ready.
interface tiny_dnn_stream_host_if
   import tiny_dnn_stream_pkg::*;
#(
   parameter int unsigned DW = DwDef
) ();

   logic          valid;
   logic [DW-1:0] data;
   logic          last;
   logic          ready;

   modport master (output valid, output data, output last, input ready);
   modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/tiny_dnn_stream_tx.sv
// Source frame memory and streamer: a head register plus one skid register,
// refilled from a synchronous memory read so ready never reaches the read address.
module tiny_dnn_stream_tx
   import tiny_dnn_stream_pkg::*;
#(
   parameter int unsigned DW = DwDef,
   parameter int unsigned AW = AwDef
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start_i,
   input  logic [AW:0]            len_i,
   input  logic                   mem_we_i,
   input  logic [AW-1:0]          mem_wa_i,
   input  logic [DW-1:0]          mem_wd_i,
   tiny_dnn_stream_host_if.master src,
   output logic                   fin_o
);

   localparam logic [AW:0] LenOne = (AW+1)'(1);

   logic [DW-1:0] src_mem [2**AW];

   logic          active_q, active_d;
   logic [AW:0]   len_q, len_d;
   logic [AW:0]   issue_cnt_q, issue_cnt_d;
   logic [1:0]    occ_q, occ_d;
   logic [DW-1:0] head_data_q, head_data_d;
   logic          head_last_q, head_last_d;
   logic [DW-1:0] skid_data_q, skid_data_d;
   logic          skid_last_q, skid_last_d;

   logic          pop;
   logic          issue;
   logic [DW-1:0] rd_word;
   logic          rd_last;

   // Source memory write port; not reset so preloaded frames survive rst.
   always_ff @(posedge clk) begin
      if (mem_we_i) src_mem[mem_wa_i] <= mem_wd_i;
   end

   // Issue a read whenever a slot is free; with occ==1 the pop frees the head
   // in the same cycle, which sustains one word per cycle.
   always_comb begin
      pop         = (occ_q != 2'd0) & src.ready;
      issue       = active_q & (issue_cnt_q != len_q) & (occ_q != 2'd2);
      rd_word     = src_mem[issue_cnt_q[AW-1:0]];
      rd_last     = (issue_cnt_q == len_q - LenOne);
      fin_o       = pop & head_last_q;

      active_d    = active_q;
      len_d       = len_q;
      issue_cnt_d = issue_cnt_q;
      occ_d       = occ_q;
      head_data_d = head_data_q;
      head_last_d = head_last_q;
      skid_data_d = skid_data_q;
      skid_last_d = skid_last_q;

      if (start_i) begin
         active_d    = 1'b1;
         len_d       = len_i;
         issue_cnt_d = '0;
      end else begin
         if (issue) issue_cnt_d = issue_cnt_q + LenOne;
         if (fin_o) active_d = 1'b0;
      end

      case (occ_q)
         2'd0: begin
            if (issue) begin
               head_data_d = rd_word;
               head_last_d = rd_last;
               occ_d       = 2'd1;
            end
         end
         2'd1: begin
            if (pop && issue) begin
               head_data_d = rd_word;
               head_last_d = rd_last;
            end else if (pop) begin
               occ_d = 2'd0;
            end else if (issue) begin
               skid_data_d = rd_word;
               skid_last_d = rd_last;
               occ_d       = 2'd2;
            end
         end
         2'd2: begin
            if (pop) begin
               head_data_d = skid_data_q;
               head_last_d = skid_last_q;
               occ_d       = 2'd1;
            end
         end
         default: occ_d = 2'd0;
      endcase
   end

   // Streamer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         active_q    <= 1'b0;
         len_q       <= '0;
         issue_cnt_q <= '0;
         occ_q       <= 2'd0;
         head_data_q <= '0;
         head_last_q <= 1'b0;
         skid_data_q <= '0;
         skid_last_q <= 1'b0;
      end else begin
         active_q    <= active_d;
         len_q       <= len_d;
         issue_cnt_q <= issue_cnt_d;
         occ_q       <= occ_d;
         head_data_q <= head_data_d;
         head_last_q <= head_last_d;
         skid_data_q <= skid_data_d;
         skid_last_q <= skid_last_d;
      end
   end

   // Head register drives the stream; last is masked once the frame drains.
   always_comb begin
      src.valid = (occ_q != 2'd0);
      src.data  = head_data_q;
      src.last  = head_last_q & (occ_q != 2'd0);
   end

endmodule

// File: rtl/tiny_dnn_stream_host.sv
// Host stream endpoint: sends a preloaded source frame, captures the result frame.
module tiny_dnn_stream_host
   import tiny_dnn_stream_pkg::*;
#(
   parameter int unsigned DW = DwDef,
   parameter int unsigned AW = AwDef
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [AW:0]            src_len,
   input  logic [AW:0]            dst_len,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   input  logic                   mem_we,
   input  logic [AW-1:0]          mem_wa,
   input  logic [DW-1:0]          mem_wd,
   input  logic [AW-1:0]          rd_a,
   output logic [DW-1:0]          rd_d,
   tiny_dnn_stream_host_if.master src,
   tiny_dnn_stream_host_if.slave  dst
);

   localparam logic [AW:0] LenOne = (AW+1)'(1);

   logic [DW-1:0] res_mem [2**AW];

   state_e        state_q, state_d;
   logic [AW:0]   dlen_q, dlen_d;
   logic [AW:0]   rcnt_q, rcnt_d;
   logic          err_q, err_d;
   logic [DW-1:0] rd_d_q;

   logic          tx_start;
   logic          tx_fin;
   logic          src_mem_we;
   logic          res_we;
   logic          rcnt_final;

   // Frame in flight is protected from host writes.
   assign src_mem_we = mem_we & ~busy;
   assign tx_start   = start & (state_q == StIdle) & (src_len != '0);

   tiny_dnn_stream_tx #(
      .DW (DW),
      .AW (AW)
   ) u_tx (
      .clk      (clk),
      .rst      (rst),
      .start_i  (tx_start),
      .len_i    (src_len),
      .mem_we_i (src_mem_we),
      .mem_wa_i (mem_wa),
      .mem_wd_i (mem_wd),
      .src      (src),
      .fin_o    (tx_fin)
   );

   // Transfer sequencing, receive counter and framing check.
   always_comb begin
      state_d    = state_q;
      dlen_d     = dlen_q;
      rcnt_d     = rcnt_q;
      err_d      = err_q;
      res_we     = 1'b0;
      rcnt_final = (rcnt_q == dlen_q - LenOne);

      case (state_q)
         StIdle: begin
            if (start) begin
               dlen_d = dst_len;
               rcnt_d = '0;
               err_d  = 1'b0;
               if (src_len != '0)      state_d = StSend;
               else if (dst_len != '0) state_d = StRecv;
               else                    state_d = StDone;
            end
         end
         StSend: begin
            if (tx_fin) state_d = (dlen_q != '0) ? StRecv : StDone;
         end
         StRecv: begin
            if (dst.valid) begin
               res_we = 1'b1;
               rcnt_d = rcnt_q + LenOne;
               // Early last or missing last on the final word both end the frame.
               if (dst.last || rcnt_final) begin
                  state_d = StDone;
                  if (dst.last != rcnt_final) err_d = 1'b1;
               end
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         dlen_q  <= '0;
         rcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dlen_q  <= dlen_d;
         rcnt_q  <= rcnt_d;
         err_q   <= err_d;
      end
   end

   // Result memory capture and registered host read port.
   always_ff @(posedge clk) begin
      if (res_we) res_mem[rcnt_q[AW-1:0]] <= dst.data;
      rd_d_q <= res_mem[rd_a];
   end

   // Status outputs decoded from the state register.
   always_comb begin
      busy      = (state_q == StSend) | (state_q == StRecv);
      done      = (state_q == StDone);
      err       = err_q;
      dst.ready = (state_q == StRecv);
      rd_d      = rd_d_q;
   end

endmodule

// File: tb/tb_tiny_dnn_stream_host.sv
// Directed bench for tiny_dnn_stream_host with hand-computed expectations.
module tb_tiny_dnn_stream_host;
   import tiny_dnn_stream_pkg::*;

   localparam int AW = 12;

   logic        clk;
   logic        rst;
   logic        start;
   logic [12:0] src_len;
   logic [12:0] dst_len;
   logic        busy;
   logic        done;
   logic        err;
   logic        mem_we;
   logic [11:0] mem_wa;
   word_t       mem_wd;
   logic [11:0] rd_a;
   word_t       rd_d;

   int n_tests = 0;
   int n_fail  = 0;

   word_t model [8];

   tiny_dnn_stream_host_if #(.DW(32)) src_if ();
   tiny_dnn_stream_host_if #(.DW(32)) dst_if ();

   tiny_dnn_stream_host #(
      .DW (32),
      .AW (AW)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .src_len (src_len),
      .dst_len (dst_len),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .mem_we  (mem_we),
      .mem_wa  (mem_wa),
      .mem_wd  (mem_wd),
      .rd_a    (rd_a),
      .rd_d    (rd_d),
      .src     (src_if),
      .dst     (dst_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a transfer and consumes the source frame; mode 0 ready=1, mode 1 toggles.
   task automatic send_frame(input int len, input int dl, input int mode);
      int    k;
      int    cyc;
      logic  held_v;
      word_t held_d;
      logic  held_l;
      logic  rdy;
      bit    pat [4];
      pat    = '{1'b1, 1'b0, 1'b0, 1'b1};
      k      = 0;
      cyc    = 1;
      held_v = 1'b0;
      held_d = '0;
      held_l = 1'b0;
      src_len = 13'(len);
      dst_len = 13'(dl);
      start   = 1'b1;
      tick();
      start = 1'b0;
      while (k < len && cyc < 200) begin
         if (mode == 1) begin
            mem_we = (cyc == 1);
            mem_wa = 12'd7;
            mem_wd = 32'hDEAD_BEEF;
         end
         check_eq("dst_rdy_in_send", dst_if.ready, 1'b0);
         if (held_v) begin
            check_eq("stall_valid", src_if.valid, 1'b1);
            check_eq("stall_data", src_if.data, held_d);
            check_eq("stall_last", src_if.last, held_l);
         end
         if (mode == 0 && cyc == 1) check_eq("first_valid_lat", src_if.valid, 1'b0);
         rdy = (mode == 0) ? 1'b1 : pat[cyc % 4];
         src_if.ready = rdy;
         if (src_if.valid && rdy) begin
            check_eq("src_data", src_if.data, model[k]);
            check_eq("src_last", src_if.last, (k == len - 1));
            if (mode == 0) check_eq("valid_timing", cyc, 2 + k);
            k++;
            held_v = 1'b0;
         end else if (src_if.valid) begin
            held_v = 1'b1;
            held_d = src_if.data;
            held_l = src_if.last;
         end
         tick();
         cyc++;
      end
      mem_we       = 1'b0;
      src_if.ready = 1'b0;
      check_eq("send_count", k, len);
      check_eq("valid_drop", src_if.valid, 1'b0);
   endtask

   // Offers result words until n handshakes complete; dst_last on index last_idx.
   task automatic recv_frame(input int n, input int last_idx, input word_t base);
      int   j;
      int   cyc;
      logic rdy;
      j   = 0;
      cyc = 0;
      while (j < n && cyc < 100) begin
         dst_if.valid = 1'b1;
         dst_if.data  = base + word_t'(j);
         dst_if.last  = (j == last_idx);
         rdy = dst_if.ready;
         tick();
         cyc++;
         if (rdy) j++;
      end
      dst_if.valid = 1'b0;
      dst_if.last  = 1'b0;
      check_eq("recv_count", j, n);
   endtask

   task automatic expect_done(input logic exp_err);
      check_eq("done_pulse", done, 1'b1);
      check_eq("busy_in_done", busy, 1'b0);
      check_eq("err_at_done", err, exp_err);
      tick();
      check_eq("done_single", done, 1'b0);
      check_eq("busy_after", busy, 1'b0);
   endtask

   task automatic read_res(input int a, input word_t exp);
      rd_a = 12'(a);
      tick();
      check_eq("rd_d", rd_d, exp);
   endtask

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      src_len      = '0;
      dst_len      = '0;
      mem_we       = 1'b0;
      mem_wa       = '0;
      mem_wd       = '0;
      rd_a         = '0;
      src_if.ready = 1'b0;
      dst_if.valid = 1'b0;
      dst_if.data  = '0;
      dst_if.last  = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = 32'h3F80_0000 + word_t'(i);

      repeat (3) tick();
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_done", done, 1'b0);
      check_eq("rst_err", err, 1'b0);
      check_eq("rst_src_valid", src_if.valid, 1'b0);
      check_eq("rst_src_last", src_if.last, 1'b0);
      check_eq("rst_src_data", src_if.data, 32'h0);
      check_eq("rst_dst_ready", dst_if.ready, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) begin
         mem_we = 1'b1;
         mem_wa = 12'(i);
         mem_wd = model[i];
         tick();
      end
      mem_we = 1'b0;

      // Send-only frame at full rate, with a stray dst_valid that must be ignored.
      dst_if.valid = 1'b1;
      send_frame(8, 0, 0);
      expect_done(1'b0);
      dst_if.valid = 1'b0;

      // Same frame with back-pressure and a write attempt to word 7 while busy.
      send_frame(8, 0, 1);
      expect_done(1'b0);

      // Send then receive a clean three-word result.
      send_frame(4, 3, 0);
      recv_frame(3, 2, 32'h4000_0000);
      expect_done(1'b0);
      for (int j = 0; j < 3; j++) read_res(j, 32'h4000_0000 + word_t'(j));

      // Early dst_last on the second of four words.
      src_len = '0;
      dst_len = 13'd4;
      start   = 1'b1;
      tick();
      start = 1'b0;
      check_eq("recv_busy", busy, 1'b1);
      check_eq("recv_dst_ready", dst_if.ready, 1'b1);
      recv_frame(2, 1, 32'h4100_0000);
      expect_done(1'b1);
      read_res(0, 32'h4100_0000);
      read_res(1, 32'h4100_0001);
      read_res(2, 32'h4000_0002);

      // Empty transfer: done in the cycle after start, err cleared.
      src_len = '0;
      dst_len = '0;
      start   = 1'b1;
      tick();
      start = 1'b0;
      check_eq("empty_src_valid", src_if.valid, 1'b0);
      check_eq("empty_dst_ready", dst_if.ready, 1'b0);
      expect_done(1'b0);

      // Reset while word 3 of 8 is presented.
      src_len      = 13'd8;
      dst_len      = '0;
      src_if.ready = 1'b1;
      start        = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      check_eq("abort_word3", src_if.data, model[3]);
      rst = 1'b1;
      tick();
      rst          = 1'b0;
      src_if.ready = 1'b0;
      check_eq("abort_valid", src_if.valid, 1'b0);
      check_eq("abort_busy", busy, 1'b0);
      check_eq("abort_done", done, 1'b0);
      tick();
      check_eq("abort_done_later", done, 1'b0);
      send_frame(8, 0, 0);
      expect_done(1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
